// File: rtl/pipeline_stall_sequencer_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encodings,
// default sizing and the stall-cause priority ordering.
package pipeline_stall_sequencer_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } state_e;

    // Stall causes, encoded so that a numerically larger cause wins
    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_FLUSH    = 3'd1,
        CAUSE_LOAD_USE = 3'd2,
        CAUSE_MDU      = 3'd3,
        CAUSE_DMEM     = 3'd4
    } stall_cause_e;

    localparam int DEF_MDU_LATENCY = 32;
    localparam int DEF_CNT_W       = 6;
    localparam int DEF_PERF_W      = 32;

endpackage

// File: rtl/pipeline_stall_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipeline_stall_sequencer_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_in,
    input  logic         clr_in,
    output logic [W-1:0] count_out
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_in) begin
            cnt_d = '0;
        end else if (inc_in && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_out = cnt_q;

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges load-use bubbles,
// iterative mul/div freezes, data-memory waits and branch/jump flushes into register enables.
module pipeline_stall_sequencer
    import pipeline_stall_sequencer_pkg::*;
#(
    parameter int MDU_LATENCY = DEF_MDU_LATENCY,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PERF_W      = DEF_PERF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_use_stall_in,
    input  logic              branch_taken_in,
    input  logic              jump_in,
    input  logic              mdu_start_in,
    input  logic              dmem_wait_in,
    input  logic              perf_clr_in,
    output logic              PCWrite_out,
    output logic              IF_ID_write_out,
    output logic              IF_ID_flush_out,
    output logic              ID_EX_hold_out,
    output logic              ID_EX_nop_out,
    output logic              EX_MEM_hold_out,
    output logic              EX_MEM_nop_out,
    output logic              mdu_busy_out,
    output logic              mdu_done_out,
    output logic              proto_err_out,
    output logic [PERF_W-1:0] stall_cycles_out
);

    localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  mdu_cnt_q, mdu_cnt_d;
    logic              proto_err_q, proto_err_d;
    stall_cause_e      cause;
    logic              mdu_last;

    assign mdu_last = (state_q == ST_MDU_BUSY) && (mdu_cnt_q == '0);

    always_comb begin
        cause = CAUSE_NONE;
        if (dmem_wait_in) begin
            cause = CAUSE_DMEM;
        end else if (state_q == ST_MDU_BUSY) begin
            cause = CAUSE_MDU;
        end else if (load_use_stall_in) begin
            cause = CAUSE_LOAD_USE;
        end else if (branch_taken_in || jump_in) begin
            cause = CAUSE_FLUSH;
        end
    end

    // MDU sequencing runs regardless of dmem_wait: the multiplier keeps iterating
    always_comb begin
        state_d     = state_q;
        mdu_cnt_d   = mdu_cnt_q;
        proto_err_d = proto_err_q;
        case (state_q)
            ST_RUN: begin
                if (mdu_start_in) begin
                    state_d   = ST_MDU_BUSY;
                    mdu_cnt_d = MDU_LOAD;
                end
            end
            ST_MDU_BUSY: begin
                if (mdu_start_in) begin
                    proto_err_d = 1'b1;
                end
                if (mdu_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    mdu_cnt_d = mdu_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            mdu_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // While reset is held the pipeline is kept empty: PC frozen and bubbles everywhere
    always_comb begin
        PCWrite_out     = 1'b1;
        IF_ID_write_out = 1'b1;
        IF_ID_flush_out = 1'b0;
        ID_EX_hold_out  = 1'b0;
        ID_EX_nop_out   = 1'b0;
        EX_MEM_hold_out = 1'b0;
        EX_MEM_nop_out  = 1'b0;
        if (rst) begin
            PCWrite_out     = 1'b0;
            IF_ID_write_out = 1'b0;
            IF_ID_flush_out = 1'b1;
            ID_EX_nop_out   = 1'b1;
            EX_MEM_nop_out  = 1'b1;
        end else begin
            case (cause)
                CAUSE_DMEM: begin
                    PCWrite_out     = 1'b0;
                    IF_ID_write_out = 1'b0;
                    ID_EX_hold_out  = 1'b1;
                    EX_MEM_hold_out = 1'b1;
                end
                CAUSE_MDU: begin
                    PCWrite_out     = 1'b0;
                    IF_ID_write_out = 1'b0;
                    ID_EX_hold_out  = 1'b1;
                    EX_MEM_nop_out  = 1'b1;
                end
                CAUSE_LOAD_USE: begin
                    PCWrite_out     = 1'b0;
                    IF_ID_write_out = 1'b0;
                    ID_EX_nop_out   = 1'b1;
                end
                CAUSE_FLUSH: begin
                    IF_ID_flush_out = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mdu_busy_out  = !rst && (state_q == ST_MDU_BUSY);
    assign mdu_done_out  = !rst && mdu_last;
    assign proto_err_out = proto_err_q;

    pipeline_stall_sequencer_sat_counter #(
        .W (PERF_W)
    ) u_stall_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc_in    (!PCWrite_out && !rst),
        .clr_in    (perf_clr_in),
        .count_out (stall_cycles_out)
    );

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed expected outputs per cycle, a monitor
// pops and compares at the falling edge.
module tb_pipeline_stall_sequencer;

    localparam int L  = 4;
    localparam int PW = 3;

    // control pattern bits: {PCWrite, IF_ID_write, IF_ID_flush, ID_EX_hold, ID_EX_nop,
    //                        EX_MEM_hold, EX_MEM_nop, mdu_busy, mdu_done}
    localparam logic [8:0] RST  = 9'b0_0_1_0_1_0_1_0_0;
    localparam logic [8:0] NORM = 9'b1_1_0_0_0_0_0_0_0;
    localparam logic [8:0] BR   = 9'b1_1_1_0_0_0_0_0_0;
    localparam logic [8:0] LU   = 9'b0_0_0_0_1_0_0_0_0;
    localparam logic [8:0] BSY  = 9'b0_0_0_1_0_0_1_1_0;
    localparam logic [8:0] DONE = 9'b0_0_0_1_0_0_1_1_1;
    localparam logic [8:0] DW   = 9'b0_0_0_1_0_1_0_0_0;
    localparam logic [8:0] DWB  = 9'b0_0_0_1_0_1_0_1_0;

    // input bits: {rst, load_use, branch, jump, mdu_start, dmem_wait, perf_clr}
    localparam logic [6:0] I_RST   = 7'b1000000;
    localparam logic [6:0] I_IDLE  = 7'b0000000;
    localparam logic [6:0] I_LU    = 7'b0100000;
    localparam logic [6:0] I_LUBR  = 7'b0110000;
    localparam logic [6:0] I_BR    = 7'b0010000;
    localparam logic [6:0] I_JMP   = 7'b0001000;
    localparam logic [6:0] I_START = 7'b0000100;
    localparam logic [6:0] I_DMEM  = 7'b0000010;
    localparam logic [6:0] I_DMST  = 7'b0000110;
    localparam logic [6:0] I_CLR   = 7'b0000001;
    localparam logic [6:0] I_LUCLR = 7'b0100001;

    typedef struct packed {
        logic [8:0]    ctrl;
        logic          perr;
        logic [PW-1:0] cnt;
        int            idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_use_stall_in = 1'b0, branch_taken_in = 1'b0, jump_in = 1'b0;
    logic mdu_start_in = 1'b0, dmem_wait_in = 1'b0, perf_clr_in = 1'b0;
    logic PCWrite_out, IF_ID_write_out, IF_ID_flush_out, ID_EX_hold_out, ID_EX_nop_out;
    logic EX_MEM_hold_out, EX_MEM_nop_out, mdu_busy_out, mdu_done_out, proto_err_out;
    logic [PW-1:0] stall_cycles_out;

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    pipeline_stall_sequencer #(
        .MDU_LATENCY (L),
        .CNT_W       (6),
        .PERF_W      (PW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .load_use_stall_in (load_use_stall_in),
        .branch_taken_in   (branch_taken_in),
        .jump_in           (jump_in),
        .mdu_start_in      (mdu_start_in),
        .dmem_wait_in      (dmem_wait_in),
        .perf_clr_in       (perf_clr_in),
        .PCWrite_out       (PCWrite_out),
        .IF_ID_write_out   (IF_ID_write_out),
        .IF_ID_flush_out   (IF_ID_flush_out),
        .ID_EX_hold_out    (ID_EX_hold_out),
        .ID_EX_nop_out     (ID_EX_nop_out),
        .EX_MEM_hold_out   (EX_MEM_hold_out),
        .EX_MEM_nop_out    (EX_MEM_nop_out),
        .mdu_busy_out      (mdu_busy_out),
        .mdu_done_out      (mdu_done_out),
        .proto_err_out     (proto_err_out),
        .stall_cycles_out  (stall_cycles_out)
    );

    task automatic step(input logic [6:0] in, input logic [8:0] ctrl,
                        input logic perr, input logic [PW-1:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        {rst, load_use_stall_in, branch_taken_in, jump_in,
         mdu_start_in, dmem_wait_in, perf_clr_in} = in;
        e.ctrl = ctrl;
        e.perr = perr;
        e.cnt  = cnt;
        e.idx  = step_no;
        sb_q.push_back(e);
        step_no++;
    endtask

    // Monitor: outputs are valid every cycle once stimulus is queued
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {PCWrite_out, IF_ID_write_out, IF_ID_flush_out, ID_EX_hold_out,
                       ID_EX_nop_out, EX_MEM_hold_out, EX_MEM_nop_out, mdu_busy_out,
                       mdu_done_out};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl step %0d: got %b expected %b", e.idx, act, e.ctrl);
                end
                checks++;
                if (proto_err_out !== e.perr) begin
                    errors++;
                    $display("FAIL proto_err step %0d: got %b expected %b", e.idx, proto_err_out, e.perr);
                end
                checks++;
                if (stall_cycles_out !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_cycles step %0d: got %0d expected %0d", e.idx, stall_cycles_out, e.cnt);
                end
            end
        end
    end

    initial begin
        // reset, then a single mul/div op of latency 4
        step(I_RST,   RST,  1'b0, 3'd0);
        step(I_IDLE,  NORM, 1'b0, 3'd0);
        step(I_START, NORM, 1'b0, 3'd0);
        step(I_IDLE,  BSY,  1'b0, 3'd0);
        step(I_IDLE,  BSY,  1'b0, 3'd1);
        step(I_IDLE,  BSY,  1'b0, 3'd2);
        step(I_IDLE,  DONE, 1'b0, 3'd3);
        step(I_IDLE,  NORM, 1'b0, 3'd4);
        step(I_CLR,   NORM, 1'b0, 3'd4);
        step(I_IDLE,  NORM, 1'b0, 3'd0);
        // reset in the middle of an MDU op
        step(I_START, NORM, 1'b0, 3'd0);
        step(I_IDLE,  BSY,  1'b0, 3'd0);
        step(I_IDLE,  BSY,  1'b0, 3'd1);
        step(I_RST,   RST,  1'b0, 3'd0);
        step(I_RST,   RST,  1'b0, 3'd0);
        step(I_IDLE,  NORM, 1'b0, 3'd0);
        // load-use beats branch, then branch/jump flush
        step(I_LUBR,  LU,   1'b0, 3'd0);
        step(I_BR,    BR,   1'b0, 3'd1);
        step(I_JMP,   BR,   1'b0, 3'd1);
        step(I_IDLE,  NORM, 1'b0, 3'd1);
        // dmem_wait for 3 cycles inside an MDU op
        step(I_START, NORM, 1'b0, 3'd1);
        step(I_DMEM,  DWB,  1'b0, 3'd1);
        step(I_DMEM,  DWB,  1'b0, 3'd2);
        step(I_DMEM,  DWB,  1'b0, 3'd3);
        step(I_IDLE,  DONE, 1'b0, 3'd4);
        step(I_IDLE,  NORM, 1'b0, 3'd5);
        // dmem_wait in RUN, and mdu_start accepted under dmem_wait
        step(I_DMEM,  DW,   1'b0, 3'd5);
        step(I_IDLE,  NORM, 1'b0, 3'd6);
        step(I_DMST,  DW,   1'b0, 3'd6);
        step(I_IDLE,  BSY,  1'b0, 3'd7);
        step(I_IDLE,  BSY,  1'b0, 3'd7);
        step(I_IDLE,  BSY,  1'b0, 3'd7);
        step(I_IDLE,  DONE, 1'b0, 3'd7);
        step(I_IDLE,  NORM, 1'b0, 3'd7);
        step(I_CLR,   NORM, 1'b0, 3'd7);
        step(I_IDLE,  NORM, 1'b0, 3'd0);
        // mdu_start while busy sets the sticky protocol error
        step(I_START, NORM, 1'b0, 3'd0);
        step(I_IDLE,  BSY,  1'b0, 3'd0);
        step(I_START, BSY,  1'b0, 3'd1);
        step(I_IDLE,  BSY,  1'b1, 3'd2);
        step(I_IDLE,  DONE, 1'b1, 3'd3);
        step(I_IDLE,  NORM, 1'b1, 3'd4);
        step(I_IDLE,  NORM, 1'b1, 3'd4);
        // 10 load-use cycles saturate the 3-bit counter
        step(I_CLR,   NORM, 1'b1, 3'd4);
        step(I_LU,    LU,   1'b1, 3'd0);
        step(I_LU,    LU,   1'b1, 3'd1);
        step(I_LU,    LU,   1'b1, 3'd2);
        step(I_LU,    LU,   1'b1, 3'd3);
        step(I_LU,    LU,   1'b1, 3'd4);
        step(I_LU,    LU,   1'b1, 3'd5);
        step(I_LU,    LU,   1'b1, 3'd6);
        step(I_LU,    LU,   1'b1, 3'd7);
        step(I_LU,    LU,   1'b1, 3'd7);
        step(I_LU,    LU,   1'b1, 3'd7);
        step(I_CLR,   NORM, 1'b1, 3'd7);
        step(I_IDLE,  NORM, 1'b1, 3'd0);
        step(I_LUCLR, LU,   1'b1, 3'd0);
        step(I_IDLE,  NORM, 1'b1, 3'd0);
        // only reset clears the sticky error
        step(I_RST,   RST,  1'b0, 3'd0);
        step(I_IDLE,  NORM, 1'b0, 3'd0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
